// File: rtl/drop_scheduler.sv
// drop_scheduler: arbitrates red/blue drop requests, validates the column against the
// 7x6 board-occupancy model, assigns the landing row and streams the 16x16 sprite.
module drop_scheduler #(
    parameter logic [7:0] X_ORIGIN    = 8'd24,
    parameter logic [6:0] Y_ORIGIN    = 7'd16,
    parameter logic [2:0] RED_COLOUR  = 3'b100,
    parameter logic [2:0] BLUE_COLOUR = 3'b001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       req_r,
    input  logic [7:0] col_r,
    input  logic       req_b,
    input  logic [7:0] col_b,
    output logic       grant_r,
    output logic       grant_b,
    output logic       reject,
    output logic       busy,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic [2:0] row,
    output logic [2:0] colnum,
    output logic [5:0] boardcounter,
    output logic       full
);

    typedef enum logic [1:0] {StIdle, StCheck, StDraw, StDone} state_e;

    state_e     state_q;
    logic [2:0] h_q [7];
    logic [7:0] cnt_q;
    logic       prio_blue_q;  // 1: blue wins a tie
    logic       pend_blue_q;
    logic [2:0] pend_col_q;

    logic       pick_blue;
    logic [7:0] win_col;
    logic [2:0] win_idx;
    logic [2:0] n_set;
    logic       win_ok;

    function automatic logic [7:0] pix_x(input logic [2:0] c, input logic [7:0] n);
        return X_ORIGIN + {1'b0, c, 4'b0000} + {4'b0000, n[3:0]};
    endfunction

    // Row 0 is the bottom of the board, so screen rows count down from row 5.
    function automatic logic [6:0] pix_y(input logic [2:0] r, input logic [7:0] n);
        return Y_ORIGIN + {3'd5 - r, 4'b0000} + {3'b000, n[7:4]};
    endfunction

    // Pick the winning requester and decide whether its column can take a piece.
    always_comb begin
        pick_blue = req_b && (!req_r || prio_blue_q);
        win_col   = pick_blue ? col_b : col_r;
        win_idx   = 3'd0;
        n_set     = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (win_col[i]) begin
                win_idx = 3'(i - 1);
                n_set   = n_set + 3'd1;
            end
        end
        win_ok = !win_col[0] && (n_set == 3'd1) && (h_q[win_idx] != 3'd6) && !full;
    end

    assign busy = (state_q != StIdle);
    assign full = (boardcounter == 6'd42);

    // Scheduler FSM with registered pixel stream and board bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q      <= StIdle;
            for (int i = 0; i < 7; i++) h_q[i] <= 3'd0;
            cnt_q        <= 8'd0;
            prio_blue_q  <= 1'b0;
            pend_blue_q  <= 1'b0;
            pend_col_q   <= 3'd0;
            boardcounter <= 6'd0;
            row          <= 3'd0;
            colnum       <= 3'd0;
            x            <= 8'd0;
            y            <= 7'd0;
            colour       <= 3'd0;
            grant_r      <= 1'b0;
            grant_b      <= 1'b0;
            reject       <= 1'b0;
            plot         <= 1'b0;
            done         <= 1'b0;
        end else begin
            grant_r <= 1'b0;
            grant_b <= 1'b0;
            reject  <= 1'b0;
            done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_r || req_b) begin
                        pend_blue_q <= pick_blue;
                        pend_col_q  <= win_idx;
                        if (win_ok) begin
                            grant_r     <= !pick_blue;
                            grant_b     <= pick_blue;
                            prio_blue_q <= !pick_blue;
                        end else begin
                            reject <= 1'b1;
                        end
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    // The grant pulse currently on the outputs marks an accepted drop.
                    if (grant_r || grant_b) begin
                        h_q[pend_col_q] <= h_q[pend_col_q] + 3'd1;
                        boardcounter    <= boardcounter + 6'd1;
                        row             <= h_q[pend_col_q];
                        colnum          <= pend_col_q;
                        cnt_q           <= 8'd0;
                        x               <= pix_x(pend_col_q, 8'd0);
                        y               <= pix_y(h_q[pend_col_q], 8'd0);
                        colour          <= pend_blue_q ? BLUE_COLOUR : RED_COLOUR;
                        plot            <= 1'b1;
                        state_q         <= StDraw;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StDraw: begin
                    if (cnt_q == 8'd255) begin
                        plot    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        x     <= pix_x(colnum, cnt_q + 8'd1);
                        y     <= pix_y(row, cnt_q + 8'd1);
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/drop_scheduler.md
# drop_scheduler

Sequences every piece drop into the shared 160x120 pixel write port and the 7x6 board-occupancy model. It arbitrates between the red (AI) and blue (player) drop requesters, validates the chosen column, assigns the landing row, and streams the 16x16 piece sprite as 256 consecutive plot cycles. It tracks the board fill count so the game controller can detect a drawn game.

## Interface
Parameters:
- X_ORIGIN, 24: screen x of column a's left edge.
- Y_ORIGIN, 16: screen y of the top row's top edge.
- RED_COLOUR, 3'b100: colour for red pieces.
- BLUE_COLOUR, 3'b001: colour for blue pieces.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state.
- clear  in  1  synchronous new-game clear; same effect as reset.
- req_r  in  1  red drop request, level.
- col_r  in  8  red column, one-hot: bits 7..1 = columns g..a; bit 0 is illegal.
- req_b  in  1  blue drop request, level.
- col_b  in  8  blue column, same encoding as col_r.
- grant_r, grant_b  out  1 each  1-cycle pulse: drop accepted.
- reject  out  1  1-cycle pulse: drop refused.
- busy  out  1  high in every state except IDLE.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel write enable.
- done  out  1  1-cycle pulse: sprite finished.
- row  out  3  landing row of the last grant, 0 = bottom.
- colnum  out  3  column index of the last grant, 0 = a.
- boardcounter  out  6  pieces on the board, 0..42.
- full  out  1  boardcounter == 42.

## Operation
- The FSM has four states: IDLE, CHECK, DRAW, DONE.
- Per-column height registers h[0..6] are 3 bits each, range 0..6.
- IDLE:
  - If either request is high, latch the winner's column and owner, then go to CHECK.
  - If only one request is high, that requester wins.
  - If both are high, the requester not granted last wins. The priority pointer starts at red after reset or clear. The pointer updates only on a grant, never on a reject.
- CHECK:
  - Reject when the column is not exactly one-hot in bits 7..1, when the column is full (h == 6), or when full = 1.
  - On reject: pulse reject for one cycle, leave all board state unchanged, return to IDLE.
  - On accept: pulse the owner's grant; set row = h[c] and colnum = c; increment h[c] and boardcounter; go to DRAW.
- DRAW:
  - An 8-bit counter cnt runs 0..255.
  - plot = 1 throughout.
  - x = X_ORIGIN + 16*colnum + cnt[3:0].
  - y = Y_ORIGIN + 16*(5 - row) + cnt[7:4].
  - colour is RED_COLOUR or BLUE_COLOUR according to the owner.
  - After the cnt == 255 cycle, go to DONE.
- DONE: pulse done for one cycle, then go to IDLE.
- Requests raised outside IDLE are ignored; they are not queued.
- Requesters must drop req the cycle after they see grant or reject. A request still high on return to IDLE is treated as a new drop.
- The address arithmetic is 8-bit unsigned and never overflows for the default parameters: maximum x = 135, maximum y = 111.

## Timing
- Reset and clear:
  - state = IDLE; h[*] = 0; cnt = 0; boardcounter = 0.
  - row = 0; colnum = 0; x = 0; y = 0; colour = 0.
  - grant_r, grant_b, reject, plot, done, busy and full are all 0.
  - Priority pointer = red.
- Reset or clear asserted mid-DRAW stops the sprite immediately: no done pulse, and the partially drawn pixels stay on screen.
- All outputs are registered or decoded from the state only (Moore). They do not depend combinationally on req or col.
- Cycle numbering for a request first seen in IDLE at cycle t:
  - t+1: CHECK, with grant or reject.
  - t+2 .. t+257: plot high, cnt 0..255.
  - t+258: done.
  - t+259: IDLE; the next request can be sampled.
- Round trip for a rejected drop: 2 cycles.
- full rises in the cycle after the CHECK that accepts the 42nd piece.

## Test plan
- Reset, then red drops column d (col_r = 8'b00010000): grant_r at t+1; row = 0, colnum = 3; first pixel (72, 96), last pixel (87, 111); 256 plots; done at t+258; boardcounter = 1.
- req_r and req_b both raised in the same IDLE cycle, held to completion and re-raised: red is granted first, blue second; colours 3'b100 then 3'b001.
- Seven drops into column a: drops 1..6 land on rows 0..5 (top-row y origin = 16); the 7th pulses reject with no plot, h and boardcounter unchanged.
- col_b = 8'b00000001, then 8'b00000110, then 8'h00: each is rejected within 2 cycles and the priority pointer is unchanged.
- Fill all 42 cells: full = 1 and boardcounter = 42; any further request is rejected.
- Assert clear at DRAW cnt = 100: the next cycle is IDLE with plot = 0, h = 0, boardcounter = 0, and no done pulse.
